audio_sample_reader: RTL and testbench

Reads 8-bit audio samples from external program memory at the addresses produced by the playback address state machine. Each sample is fetched over a req/ack handshake and double-buffered so the PWM/DAC stage receives a new sample on every 3 kHz sample tick. The block returns the fetched byte as `current_value`, so the address state machine can detect end-of-song, and pulses `count` to advance the address after each successful fetch.

---
 rtl/audio_pkg.sv | 22 ++
 rtl/audio_sample_reader_if.sv | 25 ++
 rtl/fetch_timeout_counter.sv | 36 +++
 rtl/audio_sample_reader.sv | 142 ++++++++++++++
 tb/tb_audio_sample_reader.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio playback path: fetch FSM states, sample
// constants and the sample rate also used by the address state machine.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } fetch_state_e;

  localparam logic [7:0]  SILENCE_SAMPLE = 8'h80;
  localparam logic [7:0]  END_MARKER     = 8'h00;
  localparam int unsigned SAMPLE_RATE_HZ = 3000;

  // The end-of-song marker is never played; it becomes mid-scale silence.
  function automatic logic [7:0] playable_sample(input logic [7:0] b,
                                                 input logic [7:0] silence);
    return (b == END_MARKER) ? silence : b;
  endfunction

endpackage

// File: rtl/audio_sample_reader_if.sv
// Program-memory read port: request/acknowledge with same-cycle read data.
interface audio_sample_reader_if #(
  parameter int unsigned AW = 24
) ();

  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_ack;
  logic [7:0]    mem_data;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_ack,
    output mem_data
  );

endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts cycles of an outstanding memory request; expired holds once TIMEOUT
// is reached until the counter is cleared.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/audio_sample_reader.sv
// Fetches 8-bit samples from program memory into a one-entry buffer and hands
// them to the PWM stage on each sample tick; reports fetched bytes for end-of-song.
module audio_sample_reader
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W  = 22,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [7:0]  SILENCE = SILENCE_SAMPLE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  sample_tick,
  input  logic [SEL_W-1:0]      song_sel,
  input  logic [ADDR_W-1:0]     endereco,
  output logic                  count,
  output logic [7:0]            current_value,
  audio_sample_reader_if.master mem,
  output logic [7:0]            sample_out,
  output logic                  sample_valid,
  output logic                  underrun,
  output logic                  timeout_err
);

  fetch_state_e state_q, state_d;

  logic                    buf_full_q, buf_full_d;
  logic [7:0]              buf_q, buf_d;
  logic [7:0]              current_value_q, current_value_d;
  logic [7:0]              sample_out_q, sample_out_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    underrun_q, underrun_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [SEL_W+ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic busy;
  logic expired;

  // Decoded from the state register so reset drops the request immediately.
  assign busy         = (state_q == REQ) || (state_q == WAIT);
  assign mem.mem_rd   = busy;
  assign mem.mem_addr = mem_addr_q;
  assign count        = (state_q == DONE);

  assign current_value = current_value_q;
  assign sample_out    = sample_out_q;
  assign sample_valid  = sample_valid_q;
  assign underrun      = underrun_q;
  assign timeout_err   = timeout_err_q;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!busy),
    .enable  (busy),
    .expired (expired)
  );

  always_comb begin
    state_d         = state_q;
    buf_full_d      = buf_full_q;
    buf_d           = buf_q;
    current_value_d = current_value_q;
    sample_out_d    = sample_out_q;
    sample_valid_d  = 1'b0;
    underrun_d      = underrun_q;
    timeout_err_d   = timeout_err_q;
    mem_addr_d      = mem_addr_q;

    // The tick looks at the registered buffer state, so a fill landing in the
    // same cycle is only seen by the next tick.
    if (sample_tick) begin
      if (!play) begin
        sample_out_d   = SILENCE;
        sample_valid_d = 1'b1;
      end else if (buf_full_q) begin
        sample_out_d   = playable_sample(buf_q, SILENCE);
        sample_valid_d = 1'b1;
        buf_full_d     = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (play && !buf_full_q) begin
          state_d    = REQ;
          mem_addr_d = {song_sel, endereco};
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mem.mem_ack) begin
          state_d         = DONE;
          buf_d           = mem.mem_data;
          current_value_d = mem.mem_data;
          buf_full_d      = 1'b1;
        end else if (expired) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      buf_full_q      <= 1'b0;
      buf_q           <= '0;
      current_value_q <= '1;
      sample_out_q    <= SILENCE;
      sample_valid_q  <= 1'b0;
      underrun_q      <= 1'b0;
      timeout_err_q   <= 1'b0;
      mem_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      buf_full_q      <= buf_full_d;
      buf_q           <= buf_d;
      current_value_q <= current_value_d;
      sample_out_q    <= sample_out_d;
      sample_valid_q  <= sample_valid_d;
      underrun_q      <= underrun_d;
      timeout_err_q   <= timeout_err_d;
      mem_addr_q      <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_audio_sample_reader.sv
// Self-checking bench for audio_sample_reader: table-driven fetch/play vectors
// plus hand-written sequences for underrun, pause, timeout and reset.
module tb_audio_sample_reader;

  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned TIMEOUT = 255;
  localparam logic [7:0]  SIL     = 8'h80;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  play;
  logic                  sample_tick;
  logic [SEL_W-1:0]      song_sel;
  logic [ADDR_W-1:0]     endereco;
  logic                  count;
  logic [7:0]            current_value;
  logic [7:0]            sample_out;
  logic                  sample_valid;
  logic                  underrun;
  logic                  timeout_err;

  audio_sample_reader_if #(.AW(SEL_W + ADDR_W)) mem ();

  audio_sample_reader #(
    .ADDR_W  (ADDR_W),
    .SEL_W   (SEL_W),
    .TIMEOUT (TIMEOUT),
    .SILENCE (SIL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .play          (play),
    .sample_tick   (sample_tick),
    .song_sel      (song_sel),
    .endereco      (endereco),
    .count         (count),
    .current_value (current_value),
    .mem           (mem),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .underrun      (underrun),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         delay;
    logic [7:0] exp_out;
  } vec_t;

  vec_t       vecs[6];
  int         checks      = 0;
  int         failures    = 0;
  int         count_pulses = 0;
  int         exp_count   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] fq[$];
  logic [7:0] last_out    = SIL;
  logic [7:0] last_cv     = 8'hFF;
  logic       exp_under   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every sample_valid pulse must match the queued expectation.
  always @(negedge clk) begin
    if (count) count_pulses++;
    if (sample_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sample_valid_unexpected actual=%0h expected=none", sample_out);
      end else begin
        chk("sample_out_scoreboard", 32'(sample_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    sample_tick = 1'b1;
    if (!play) begin
      last_out = SIL;
      exp_q.push_back(SIL);
    end else if (fq.size() > 0) begin
      last_out = fq.pop_front();
      exp_q.push_back(last_out);
    end else begin
      exp_under = 1'b1;
    end
    cyc();
    sample_tick = 1'b0;
    chk("tick_underrun", 32'(underrun), 32'(exp_under));
    chk("tick_sample_out", 32'(sample_out), 32'(last_out));
  endtask

  task automatic wait_rd(output bit ok);
    int n = 0;
    while (!mem.mem_rd && n < 20) begin
      cyc();
      n++;
    end
    ok = mem.mem_rd;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL request_wait actual=mem_rd_low expected=mem_rd_high");
    end
  endtask

  task automatic finish_ack(input logic [7:0] data, input logic [7:0] exp_out);
    chk("done_count", 32'(count), 32'd1);
    chk("done_mem_rd", 32'(mem.mem_rd), 32'd0);
    chk("done_current_value", 32'(current_value), 32'(data));
    fq.push_back(exp_out);
    exp_count++;
    last_cv  = data;
    endereco = (data == 8'h00) ? '0 : endereco + 1'b1;
    cyc();
    chk("count_single_pulse", 32'(count), 32'd0);
  endtask

  task automatic do_fetch(input logic [7:0] data, input int delay, input logic [7:0] exp_out);
    bit ok;
    wait_rd(ok);
    if (!ok) return;
    chk("mem_addr", 32'(mem.mem_addr), 32'({song_sel, endereco}));
    repeat (delay) cyc();
    mem.mem_ack  = 1'b1;
    mem.mem_data = data;
    cyc();
    mem.mem_ack  = 1'b0;
    finish_ack(data, exp_out);
  endtask

  task automatic chk_reset_values();
    chk("rst_mem_rd", 32'(mem.mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem.mem_addr), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_current_value", 32'(current_value), 32'hFF);
    chk("rst_sample_out", 32'(sample_out), 32'(SIL));
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int n;

    vecs[0] = '{8'h5A, 3, 8'h5A};
    vecs[1] = '{8'h00, 1, 8'h80};
    vecs[2] = '{8'h11, 2, 8'h11};
    vecs[3] = '{8'hFF, 5, 8'hFF};
    vecs[4] = '{8'h01, 1, 8'h01};
    vecs[5] = '{8'h80, 4, 8'h80};

    reset        = 1'b1;
    play         = 1'b0;
    sample_tick  = 1'b0;
    song_sel     = 2'd2;
    endereco     = 22'h000010;
    mem.mem_ack  = 1'b0;
    mem.mem_data = 8'h00;
    repeat (3) cyc();
    chk_reset_values();
    reset = 1'b0;
    cyc();

    // Request rises exactly one cycle after play enables the fetch.
    play = 1'b1;
    chk("mem_rd_before_req", 32'(mem.mem_rd), 32'd0);
    cyc();
    chk("mem_rd_after_req", 32'(mem.mem_rd), 32'd1);

    for (int i = 0; i < 6; i++) begin
      do_fetch(vecs[i].data, vecs[i].delay, vecs[i].exp_out);
      repeat (2) cyc();
      tick();
    end
    chk("no_underrun_yet", 32'(underrun), 32'd0);

    // Ack and tick in the same cycle with an empty buffer.
    wait_rd(ok);
    cyc();
    mem.mem_ack  = 1'b1;
    mem.mem_data = 8'h3C;
    tick();
    mem.mem_ack = 1'b0;
    chk("same_cycle_valid", 32'(sample_valid), 32'd0);
    finish_ack(8'h3C, 8'h3C);
    tick();

    // Pause while waiting: fetch completes, ticks give silence.
    wait_rd(ok);
    cyc();
    play = 1'b0;
    repeat (3) cyc();
    mem.mem_ack  = 1'b1;
    mem.mem_data = 8'h44;
    cyc();
    mem.mem_ack = 1'b0;
    finish_ack(8'h44, 8'h44);
    tick();
    repeat (5) cyc();
    chk("paused_mem_rd", 32'(mem.mem_rd), 32'd0);
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (10) cyc();
    chk("no_fetch_paused", 32'(mem.mem_rd), 32'd0);
    tick();

    // No acknowledge: request abandoned, then retried at the same address.
    play = 1'b1;
    wait_rd(ok);
    chk("timeout_err_before", 32'(timeout_err), 32'd0);
    chk("timeout_mem_addr", 32'(mem.mem_addr), 32'({song_sel, endereco}));
    n = 0;
    while (mem.mem_rd && n < 400) begin
      cyc();
      n++;
    end
    chk("timeout_rd_cycles", 32'(n), 32'(TIMEOUT + 1));
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    chk("timeout_no_count", 32'(count_pulses), 32'(exp_count));
    chk("timeout_current_value", 32'(current_value), 32'(last_cv));
    do_fetch(8'h21, 2, 8'h21);
    tick();

    // Reset in the middle of a request; a late ack must be ignored.
    wait_rd(ok);
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_values();
    play         = 1'b0;
    mem.mem_ack  = 1'b1;
    mem.mem_data = 8'h99;
    cyc();
    cyc();
    reset = 1'b0;
    last_out  = SIL;
    last_cv   = 8'hFF;
    exp_under = 1'b0;
    repeat (3) cyc();
    mem.mem_ack = 1'b0;
    chk("late_ack_count", 32'(count_pulses), 32'(exp_count));
    chk("late_ack_current_value", 32'(current_value), 32'hFF);
    chk("late_ack_mem_rd", 32'(mem.mem_rd), 32'd0);
    chk("late_ack_sample_out", 32'(sample_out), 32'(SIL));
    chk("late_ack_underrun", 32'(underrun), 32'd0);

    repeat (3) cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("total_count_pulses", 32'(count_pulses), 32'(exp_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
